// File: rtl/bsg_mcl_axil_rx_reader_if.sv
// rtl/bsg_mcl_axil_rx_reader_if.sv - AXI-Lite read channel (AR/R) bundle
// The master drives the address and rready; the slave returns the data and the response.
interface bsg_mcl_axil_rx_reader_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  logic [addr_width_p-1:0] araddr;
  logic                    arvalid;
  logic                    arready;
  logic [data_width_p-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/bsg_mcl_axil_rx_reader.sv
// rtl/bsg_mcl_axil_rx_reader.sv - AXI-Lite read endpoint that pops upstream request words
// Exposes DATA (pop), CREDITS and COUNT registers in a 16-byte window; one read is outstanding at a time.
module bsg_mcl_axil_rx_reader #(
  parameter int                           axil_data_width_p   = 32,
  parameter int                           axil_addr_width_p   = 32,
  parameter int                           req_credits_width_p = 8,
  parameter logic [axil_addr_width_p-1:0] base_addr_p         = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  bsg_mcl_axil_rx_reader_if.slave        s_axil,
  input  logic [axil_data_width_p-1:0]   axil_req_i,
  input  logic                           axil_req_v_i,
  output logic                           axil_req_ready_o,
  input  logic [req_credits_width_p-1:0] req_credits_i
);

  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;
  localparam logic [1:0] resp_decerr_lp = 2'b11;

  typedef enum logic {IDLE, RESP} state_e;

  state_e                         state_q, state_d;
  logic [axil_data_width_p-1:0]   rdata_q, rdata_d;
  logic [1:0]                     rresp_q, rresp_d;
  logic [axil_data_width_p-1:0]   count_q, count_d;

  logic                           window_hit;
  logic                           data_hit;
  logic [axil_data_width_p-1:0]   credits_ext;

  always_comb begin
    window_hit = (s_axil.araddr[axil_addr_width_p-1:4] == base_addr_p[axil_addr_width_p-1:4])
              && (s_axil.araddr[1:0] == 2'b00);
    data_hit   = window_hit && (s_axil.araddr[3:2] == 2'd0);
    credits_ext = '0;
    credits_ext[req_credits_width_p-1:0] = req_credits_i;
  end

  always_comb begin
    state_d          = state_q;
    rdata_d          = rdata_q;
    rresp_d          = rresp_q;
    count_d          = count_q;
    // Pop is combinational on upstream valid; upstream valid never waits on ready.
    axil_req_ready_o = (state_q == IDLE) && s_axil.arvalid && data_hit && axil_req_v_i;

    unique case (state_q)
      IDLE: begin
        if (s_axil.arvalid) begin
          state_d = RESP;
          if (!window_hit) begin
            rdata_d = '0;
            rresp_d = resp_decerr_lp;
          end else begin
            rresp_d = resp_okay_lp;
            unique case (s_axil.araddr[3:2])
              2'd0: begin
                if (axil_req_v_i) begin
                  rdata_d = axil_req_i;
                  count_d = count_q + 1'b1;
                end else begin
                  rdata_d = '0;
                  rresp_d = resp_slverr_lp;
                end
              end
              2'd1:    rdata_d = credits_ext;
              2'd2:    rdata_d = count_q;
              default: rdata_d = '0;
            endcase
          end
        end
      end
      RESP: begin
        if (s_axil.rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      rresp_q <= resp_okay_lp;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      count_q <= count_d;
    end
  end

  assign s_axil.arready = (state_q == IDLE);
  assign s_axil.rvalid  = (state_q == RESP);
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

endmodule

// File: tb/tb_bsg_mcl_axil_rx_reader.sv
// tb/tb_bsg_mcl_axil_rx_reader.sv - directed bench for bsg_mcl_axil_rx_reader
module tb_bsg_mcl_axil_rx_reader;
  localparam logic [31:0] base_lp = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] axil_req = '0;
  logic        axil_req_v = 1'b0;
  logic        axil_req_ready;
  logic [7:0]  req_credits = 8'd0;

  int checks = 0;
  int failures = 0;
  int pop_cnt = 0;

  bsg_mcl_axil_rx_reader_if #(.addr_width_p(32), .data_width_p(32)) axil ();

  bsg_mcl_axil_rx_reader #(
    .axil_data_width_p  (32),
    .axil_addr_width_p  (32),
    .req_credits_width_p(8),
    .base_addr_p        (base_lp)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .s_axil          (axil),
    .axil_req_i      (axil_req),
    .axil_req_v_i    (axil_req_v),
    .axil_req_ready_o(axil_req_ready),
    .req_credits_i   (req_credits)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axil_req_v && axil_req_ready) pop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One read with rready held high; returns the captured response.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    axil.araddr  = addr;
    axil.arvalid = 1'b1;
    n = 0;
    while (!axil.arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("arready_timeout", 32'(axil.arready), 32'd1);
    @(posedge clk);
    #1;
    axil.arvalid = 1'b0;
    axil.araddr  = '0;
    @(negedge clk);
    check("rvalid_next_cycle", 32'(axil.rvalid), 32'd1);
    data = axil.rdata;
    resp = axil.rresp;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [31:0] held;
  int          pops_before;

  initial begin
    axil.araddr  = '0;
    axil.arvalid = 1'b0;
    axil.rready  = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_arready", 32'(axil.arready), 32'd1);
    check("rst_rvalid", 32'(axil.rvalid), 32'd0);
    check("rst_rdata", axil.rdata, 32'd0);
    check("rst_rresp", 32'(axil.rresp), 32'd0);
    check("rst_req_ready", 32'(axil_req_ready), 32'd0);
    reset = 1'b0;

    do_read(base_lp + 32'h8, d, r);
    check("count_init", d, 32'd0);
    check("count_init_resp", 32'(r), 32'd0);

    axil_req = 32'hA5A5_0001;
    axil_req_v = 1'b1;
    do_read(base_lp, d, r);
    check("data0", d, 32'hA5A5_0001);
    check("data0_resp", 32'(r), 32'd0);
    check("arready_back_n2", 32'(axil.arready), 32'd1);
    axil_req = 32'hA5A5_0002;
    do_read(base_lp, d, r);
    check("data1", d, 32'hA5A5_0002);
    check("data1_resp", 32'(r), 32'd0);
    axil_req_v = 1'b0;
    axil_req = '0;
    check("two_pops", 32'(pop_cnt), 32'd2);
    do_read(base_lp + 32'h8, d, r);
    check("count_two", d, 32'd2);

    do_read(base_lp, d, r);
    check("empty_data", d, 32'd0);
    check("empty_resp", 32'(r), 32'd2);
    check("empty_no_pop", 32'(pop_cnt), 32'd2);
    do_read(base_lp + 32'h8, d, r);
    check("count_after_empty", d, 32'd2);

    // rready stall: arvalid stays asserted on DATA to show no extra pop
    axil_req = 32'h1234_5678;
    axil_req_v = 1'b1;
    axil.rready = 1'b0;
    pops_before = pop_cnt;
    @(negedge clk);
    axil.araddr = base_lp;
    axil.arvalid = 1'b1;
    @(posedge clk);
    #1;
    held = axil.rdata;
    check("stall_first_rdata", held, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rvalid", 32'(axil.rvalid), 32'd1);
      check("stall_rdata", axil.rdata, held);
      check("stall_arready", 32'(axil.arready), 32'd0);
    end
    axil.arvalid = 1'b0;
    axil.araddr = '0;
    axil.rready = 1'b1;
    @(posedge clk);
    #1;
    check("stall_single_pop", 32'(pop_cnt - pops_before), 32'd1);
    axil_req = 32'hDEAD_BEEF;

    do_read(base_lp + 32'h10, d, r);
    check("dec_hi_resp", 32'(r), 32'd3);
    check("dec_hi_data", d, 32'd0);
    do_read(base_lp + 32'h2, d, r);
    check("dec_lo_resp", 32'(r), 32'd3);
    check("dec_lo_data", d, 32'd0);
    check("dec_no_pop", 32'(pop_cnt - pops_before), 32'd1);
    req_credits = 8'd7;
    do_read(base_lp + 32'h4, d, r);
    check("credits", d, 32'd7);
    do_read(base_lp + 32'hC, d, r);
    check("reserved_data", d, 32'd0);
    check("reserved_resp", 32'(r), 32'd0);
    axil_req_v = 1'b0;

    do_read(base_lp + 32'h8, d, r);
    check("count_three", d, 32'd3);

    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.count_q;
    do_read(base_lp + 32'h8, d, r);
    check("count_max", d, 32'hFFFF_FFFF);
    axil_req = 32'h0000_0042;
    axil_req_v = 1'b1;
    do_read(base_lp, d, r);
    check("wrap_pop_data", d, 32'h0000_0042);
    axil_req_v = 1'b0;
    do_read(base_lp + 32'h8, d, r);
    check("count_wrap", d, 32'd0);

    // reset while RESP is pending
    axil_req_v = 1'b1;
    axil.rready = 1'b0;
    @(negedge clk);
    axil.araddr = base_lp;
    axil.arvalid = 1'b1;
    @(posedge clk);
    #1;
    axil.arvalid = 1'b0;
    @(negedge clk);
    check("pre_reset_rvalid", 32'(axil.rvalid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_resp_rvalid", 32'(axil.rvalid), 32'd0);
    check("reset_in_resp_arready", 32'(axil.arready), 32'd1);
    reset = 1'b0;
    axil_req_v = 1'b0;
    axil.rready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
